// File: rtl/sram_access_arbiter_if.sv
// sram_access_arbiter_if: client request/ack buses and the single SRAM port
// shared by the arbiter. The slave modport is the arbiter's view. The master
// modport is the view of the clients and the SRAM controller.
interface sram_access_arbiter_if #(
    parameter int NUM_CLIENTS     = 4,
    parameter int SRAM_ADDR_WIDTH = 19,
    parameter int SRAM_DATA_WIDTH = 72
);
    // client write channel
    logic [NUM_CLIENTS-1:0]                 cl_wr_req;
    logic [NUM_CLIENTS*SRAM_ADDR_WIDTH-1:0] cl_wr_addr;
    logic [NUM_CLIENTS*SRAM_DATA_WIDTH-1:0] cl_wr_data;
    logic [NUM_CLIENTS-1:0]                 cl_wr_ack;
    // client read channel
    logic [NUM_CLIENTS-1:0]                 cl_rd_req;
    logic [NUM_CLIENTS*SRAM_ADDR_WIDTH-1:0] cl_rd_addr;
    logic [NUM_CLIENTS-1:0]                 cl_rd_ack;
    logic [NUM_CLIENTS-1:0]                 cl_rd_vld;
    logic [SRAM_DATA_WIDTH-1:0]             cl_rd_data;
    // SRAM write port
    logic                                   wr_0_req;
    logic [SRAM_ADDR_WIDTH-1:0]             wr_0_addr;
    logic [SRAM_DATA_WIDTH-1:0]             wr_0_data;
    logic                                   wr_0_ack;
    // SRAM read port
    logic                                   rd_0_req;
    logic [SRAM_ADDR_WIDTH-1:0]             rd_0_addr;
    logic                                   rd_0_ack;
    logic                                   rd_0_vld;
    logic [SRAM_DATA_WIDTH-1:0]             rd_0_data;
    // status
    logic                                   rd_tag_err;
    logic [31:0]                            wr_grant_cnt;
    logic [31:0]                            rd_grant_cnt;

    modport slave (
        input  cl_wr_req, cl_wr_addr, cl_wr_data, cl_rd_req, cl_rd_addr,
               wr_0_ack, rd_0_ack, rd_0_vld, rd_0_data,
        output cl_wr_ack, cl_rd_ack, cl_rd_vld, cl_rd_data,
               wr_0_req, wr_0_addr, wr_0_data, rd_0_req, rd_0_addr,
               rd_tag_err, wr_grant_cnt, rd_grant_cnt
    );

    modport master (
        output cl_wr_req, cl_wr_addr, cl_wr_data, cl_rd_req, cl_rd_addr,
               wr_0_ack, rd_0_ack, rd_0_vld, rd_0_data,
        input  cl_wr_ack, cl_rd_ack, cl_rd_vld, cl_rd_data,
               wr_0_req, wr_0_addr, wr_0_data, rd_0_req, rd_0_addr,
               rd_tag_err, wr_grant_cnt, rd_grant_cnt
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: shares one SRAM write port and one SRAM read port among
// NUM_CLIENTS requesters using independent round-robin arbiters. A read-tag FIFO
// routes each returned read beat back to the client that issued it.
// Optional feature: define SRAM_ARB_STATS_EN to build saturating grant counters;
// otherwise wr_grant_cnt/rd_grant_cnt are tied to zero.
module sram_access_arbiter #(
    parameter int NUM_CLIENTS        = 4,
    parameter int SRAM_ADDR_WIDTH    = 19,
    parameter int SRAM_DATA_WIDTH    = 72,
    parameter int MAX_RD_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_access_arbiter_if.slave  bus
);
    localparam int CLIENT_ID_WIDTH = $clog2(NUM_CLIENTS);
    localparam int IDW             = CLIENT_ID_WIDTH;
    localparam int TPW             = $clog2(MAX_RD_OUTSTANDING);
    localparam int CNTW            = TPW + 1;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

    // First requester at or after start, wrapping; MSB of result flags a winner.
    function automatic logic [IDW:0] rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                             input logic [IDW-1:0] start);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
            if (req[idx[IDW-1:0]]) res = {1'b1, idx[IDW-1:0]};
        end
        return res;
    endfunction

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] g);
        if (g == IDW'(NUM_CLIENTS - 1)) return '0;
        return g + IDW'(1);
    endfunction

    // write channel state
    state_e                     wr_state_q, wr_state_d;
    logic [IDW-1:0]             wr_g_q, wr_g_d, wr_ptr_q, wr_ptr_d;
    logic [SRAM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [SRAM_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [IDW:0]               wr_pick;
    logic [NUM_CLIENTS-1:0]     wr_mask;
    logic                       wr_load;
    // read channel state
    state_e                     rd_state_q, rd_state_d;
    logic [IDW-1:0]             rd_g_q, rd_g_d, rd_ptr_q, rd_ptr_d;
    logic [SRAM_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [IDW:0]               rd_pick;
    logic [NUM_CLIENTS-1:0]     rd_mask;
    logic                       rd_load;
    // read-tag FIFO
    logic [IDW-1:0]             tag_mem_q [MAX_RD_OUTSTANDING];
    logic [TPW-1:0]             tag_wptr_q, tag_wptr_d, tag_rptr_q, tag_rptr_d;
    logic [CNTW-1:0]            tag_cnt_q, tag_cnt_d;
    logic                       tag_push, tag_pop;
    logic                       rd_tag_err_q, rd_tag_err_d;

    assign tag_push = (rd_state_q == GRANT) && bus.rd_0_ack;
    assign tag_pop  = bus.rd_0_vld && (tag_cnt_q != '0);

    // State register for both channel FSMs, the tag FIFO pointers and the error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_state_q   <= IDLE;
            wr_g_q       <= '0;
            wr_ptr_q     <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_state_q   <= IDLE;
            rd_g_q       <= '0;
            rd_ptr_q     <= '0;
            rd_addr_q    <= '0;
            tag_wptr_q   <= '0;
            tag_rptr_q   <= '0;
            tag_cnt_q    <= '0;
            rd_tag_err_q <= 1'b0;
        end else begin
            wr_state_q   <= wr_state_d;
            wr_g_q       <= wr_g_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_state_q   <= rd_state_d;
            rd_g_q       <= rd_g_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_addr_q    <= rd_addr_d;
            tag_wptr_q   <= tag_wptr_d;
            tag_rptr_q   <= tag_rptr_d;
            tag_cnt_q    <= tag_cnt_d;
            rd_tag_err_q <= rd_tag_err_d;
        end
    end

    // Tag storage holds only the client ID of each acked read; pointers gate validity.
    always_ff @(posedge clk) begin
        if (tag_push) tag_mem_q[tag_wptr_q] <= rd_g_q;
    end

    // Write FSM next state: arbitrate from IDLE, or re-arbitrate (winner masked) on ack.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_g_d     = wr_g_q;
        wr_ptr_d   = wr_ptr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_pick    = '0;
        wr_load    = 1'b0;
        wr_mask    = '0;
        wr_mask[wr_g_q] = 1'b1;
        case (wr_state_q)
            IDLE: begin
                wr_pick = rr_pick(bus.cl_wr_req, wr_ptr_q);
                if (wr_pick[IDW]) begin
                    wr_load    = 1'b1;
                    wr_state_d = GRANT;
                end
            end
            GRANT: begin
                if (bus.wr_0_ack) begin
                    wr_ptr_d = next_id(wr_g_q);
                    wr_pick  = rr_pick(bus.cl_wr_req & ~wr_mask, next_id(wr_g_q));
                    if (wr_pick[IDW]) wr_load    = 1'b1;
                    else              wr_state_d = IDLE;
                end
            end
        endcase
        if (wr_load) begin
            wr_g_d = wr_pick[IDW-1:0];
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (wr_pick[IDW-1:0] == IDW'(i)) begin
                    wr_addr_d = bus.cl_wr_addr[i*SRAM_ADDR_WIDTH +: SRAM_ADDR_WIDTH];
                    wr_data_d = bus.cl_wr_data[i*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
                end
            end
        end
    end

    // Read FSM next state: like the write side, but no grant while the tag FIFO could fill.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_g_d     = rd_g_q;
        rd_ptr_d   = rd_ptr_q;
        rd_addr_d  = rd_addr_q;
        rd_pick    = '0;
        rd_load    = 1'b0;
        rd_mask    = '0;
        rd_mask[rd_g_q] = 1'b1;
        case (rd_state_q)
            IDLE: begin
                // rd_0_req is low here, so only the tags already held count
                if (tag_cnt_q < CNTW'(MAX_RD_OUTSTANDING)) begin
                    rd_pick = rr_pick(bus.cl_rd_req, rd_ptr_q);
                    if (rd_pick[IDW]) begin
                        rd_load    = 1'b1;
                        rd_state_d = GRANT;
                    end
                end
            end
            GRANT: begin
                if (bus.rd_0_ack) begin
                    rd_ptr_d = next_id(rd_g_q);
                    // the outstanding rd_0_req also claims a tag slot
                    if (tag_cnt_q < CNTW'(MAX_RD_OUTSTANDING - 1))
                        rd_pick = rr_pick(bus.cl_rd_req & ~rd_mask, next_id(rd_g_q));
                    if (rd_pick[IDW]) rd_load    = 1'b1;
                    else              rd_state_d = IDLE;
                end
            end
        endcase
        if (rd_load) begin
            rd_g_d = rd_pick[IDW-1:0];
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (rd_pick[IDW-1:0] == IDW'(i))
                    rd_addr_d = bus.cl_rd_addr[i*SRAM_ADDR_WIDTH +: SRAM_ADDR_WIDTH];
            end
        end
    end

    // Tag FIFO bookkeeping; a return with nothing outstanding latches the error flag.
    always_comb begin
        tag_wptr_d   = tag_wptr_q;
        tag_rptr_d   = tag_rptr_q;
        tag_cnt_d    = tag_cnt_q;
        rd_tag_err_d = rd_tag_err_q;
        if (tag_push) tag_wptr_d = tag_wptr_q + TPW'(1);
        if (tag_pop)  tag_rptr_d = tag_rptr_q + TPW'(1);
        if (tag_push && !tag_pop)      tag_cnt_d = tag_cnt_q + CNTW'(1);
        else if (!tag_push && tag_pop) tag_cnt_d = tag_cnt_q - CNTW'(1);
        if (bus.rd_0_vld && (tag_cnt_q == '0)) rd_tag_err_d = 1'b1;
    end

    // Outputs: SRAM requests from state, client acks/valids combinational from SRAM strobes.
    always_comb begin
        bus.wr_0_req  = (wr_state_q == GRANT);
        bus.rd_0_req  = (rd_state_q == GRANT);
        bus.cl_wr_ack = '0;
        bus.cl_rd_ack = '0;
        bus.cl_rd_vld = '0;
        if ((wr_state_q == GRANT) && bus.wr_0_ack) bus.cl_wr_ack[wr_g_q] = 1'b1;
        if (tag_push) bus.cl_rd_ack[rd_g_q] = 1'b1;
        if (tag_pop)  bus.cl_rd_vld[tag_mem_q[tag_rptr_q]] = 1'b1;
    end

    assign bus.wr_0_addr  = wr_addr_q;
    assign bus.wr_0_data  = wr_data_q;
    assign bus.rd_0_addr  = rd_addr_q;
    assign bus.cl_rd_data = bus.rd_0_data;
    assign bus.rd_tag_err = rd_tag_err_q;

`ifdef SRAM_ARB_STATS_EN
    logic [31:0] wr_stat_q, rd_stat_q;

    // Saturating counters of accepted SRAM writes and reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_stat_q <= '0;
            rd_stat_q <= '0;
        end else begin
            if ((wr_state_q == GRANT) && bus.wr_0_ack && (wr_stat_q != '1))
                wr_stat_q <= wr_stat_q + 32'd1;
            if (tag_push && (rd_stat_q != '1))
                rd_stat_q <= rd_stat_q + 32'd1;
        end
    end

    assign bus.wr_grant_cnt = wr_stat_q;
    assign bus.rd_grant_cnt = rd_stat_q;
`else
    assign bus.wr_grant_cnt = '0;
    assign bus.rd_grant_cnt = '0;
`endif
endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter: directed vector table for the arbitration and tag
// routing plus hand-written sequences for back-pressure, reset and statistics.
module tb_sram_access_arbiter;
    localparam int N = 4;
    localparam int A = 19;
    localparam int D = 72;
    localparam int M = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sram_access_arbiter_if #(.NUM_CLIENTS(N), .SRAM_ADDR_WIDTH(A), .SRAM_DATA_WIDTH(D)) sif ();

    sram_access_arbiter #(
        .NUM_CLIENTS(N), .SRAM_ADDR_WIDTH(A), .SRAM_DATA_WIDTH(D), .MAX_RD_OUTSTANDING(M)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    typedef struct {
        logic [3:0]   wr_req, rd_req;
        logic         wr_ack, rd_ack, rd_vld;
        logic [D-1:0] rd_data;
        logic         e_wr_req;
        logic [3:0]   e_wr_ack;
        int           e_wr_cl;
        logic         e_rd_req;
        logic [3:0]   e_rd_ack, e_rd_vld;
        int           e_rd_cl;
        logic         e_err;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string nm, input logic [D-1:0] act, input logic [D-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] wq, input logic [3:0] rq,
                                input logic wa, input logic ra, input logic rv,
                                input logic [D-1:0] rdat,
                                input logic ewq, input logic [3:0] ewa, input int ewc,
                                input logic erq, input logic [3:0] era, input logic [3:0] erv,
                                input int erc, input logic eerr);
        vec_t v;
        v.wr_req = wq;   v.rd_req = rq;
        v.wr_ack = wa;   v.rd_ack = ra;   v.rd_vld = rv;  v.rd_data = rdat;
        v.e_wr_req = ewq; v.e_wr_ack = ewa; v.e_wr_cl = ewc;
        v.e_rd_req = erq; v.e_rd_ack = era; v.e_rd_vld = erv; v.e_rd_cl = erc;
        v.e_err = eerr;
        return v;
    endfunction

    task automatic do_write(input int c);
        int n;
        n = 0;
        @(negedge clk);
        sif.cl_wr_req[c] = 1'b1;
        @(negedge clk);
        while (!sif.wr_0_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("wr grant wait c%0d", c), sif.wr_0_req, 1);
        sif.wr_0_ack = 1'b1;
        #1;
        check($sformatf("wr ack c%0d", c), sif.cl_wr_ack, 1 << c);
        @(negedge clk);
        sif.wr_0_ack     = 1'b0;
        sif.cl_wr_req[c] = 1'b0;
    endtask

    task automatic do_read(input int c);
        int n;
        n = 0;
        @(negedge clk);
        sif.cl_rd_req[c] = 1'b1;
        @(negedge clk);
        while (!sif.rd_0_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("rd grant wait c%0d", c), sif.rd_0_req, 1);
        sif.rd_0_ack = 1'b1;
        #1;
        check($sformatf("rd ack c%0d", c), sif.cl_rd_ack, 1 << c);
        @(negedge clk);
        sif.rd_0_ack     = 1'b0;
        sif.cl_rd_req[c] = 1'b0;
        sif.rd_0_vld     = 1'b1;
        #1;
        check($sformatf("rd vld c%0d", c), sif.cl_rd_vld, 1 << c);
        @(negedge clk);
        sif.rd_0_vld = 1'b0;
    endtask

    initial begin
        logic [D-1:0] d1, d2, d3, d4;
        int acks, vlds, exp_w, exp_r;
        d1 = 72'hA5_0123_4567_89AB_CDEF;
        d2 = 72'h3C_DEAD_BEEF_0000_1234;
        d3 = 72'hFF_FFFF_0000_FFFF_0001;
        d4 = 72'h01_1111_2222_3333_4444;

        sif.cl_wr_req = '0; sif.cl_rd_req = '0;
        sif.wr_0_ack = 1'b0; sif.rd_0_ack = 1'b0; sif.rd_0_vld = 1'b0;
        sif.rd_0_data = '0;
        for (int i = 0; i < N; i++) begin
            sif.cl_wr_addr[i*A +: A] = A'(32'h10 + i);
            sif.cl_wr_data[i*D +: D] = D'(32'hAB + i);
            sif.cl_rd_addr[i*A +: A] = A'(32'h100 + i);
        end

        //   wr_req   rd_req   wa ra rv data  ewq ewa     ewc erq era     erv     erc err
        // single write, ack three cycles after request
        vq.push_back(mk(4'b0001, 4'b0000, 0, 0, 0, '0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0));
        vq.push_back(mk(4'b0001, 4'b0000, 0, 0, 0, '0, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0));
        vq.push_back(mk(4'b0001, 4'b0000, 0, 0, 0, '0, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0));
        vq.push_back(mk(4'b0001, 4'b0000, 1, 0, 0, '0, 1, 4'b0001, 0, 0, 4'b0000, 4'b0000, 0, 0));
        vq.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, '0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0));
        // writes from 1 and 3, back-to-back with the winner masked
        vq.push_back(mk(4'b1010, 4'b0000, 0, 0, 0, '0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0));
        vq.push_back(mk(4'b1010, 4'b0000, 1, 0, 0, '0, 1, 4'b0010, 1, 0, 4'b0000, 4'b0000, 0, 0));
        vq.push_back(mk(4'b1000, 4'b0000, 1, 0, 0, '0, 1, 4'b1000, 3, 0, 4'b0000, 4'b0000, 0, 0));
        vq.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, '0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0));
        // clients 0,1,2 read continuously, acked every cycle, returns one cycle later
        vq.push_back(mk(4'b0000, 4'b0111, 0, 0, 0, '0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0));
        vq.push_back(mk(4'b0000, 4'b0111, 0, 1, 0, '0, 0, 4'b0000, 0, 1, 4'b0001, 4'b0000, 0, 0));
        vq.push_back(mk(4'b0000, 4'b0111, 0, 1, 1, d1, 0, 4'b0000, 0, 1, 4'b0010, 4'b0001, 1, 0));
        vq.push_back(mk(4'b0000, 4'b0111, 0, 1, 1, d2, 0, 4'b0000, 0, 1, 4'b0100, 4'b0010, 2, 0));
        vq.push_back(mk(4'b0000, 4'b0111, 0, 1, 1, d3, 0, 4'b0000, 0, 1, 4'b0001, 4'b0100, 0, 0));
        vq.push_back(mk(4'b0000, 4'b0110, 0, 1, 1, d4, 0, 4'b0000, 0, 1, 4'b0010, 4'b0001, 1, 0));
        vq.push_back(mk(4'b0000, 4'b0100, 0, 1, 1, d1, 0, 4'b0000, 0, 1, 4'b0100, 4'b0010, 2, 0));
        vq.push_back(mk(4'b0000, 4'b0000, 0, 0, 1, d2, 0, 4'b0000, 0, 0, 4'b0000, 4'b0100, 0, 0));
        // client 1 writes and reads in parallel, then client 2 reads; data returned in order
        vq.push_back(mk(4'b0010, 4'b0010, 0, 0, 0, '0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0));
        vq.push_back(mk(4'b0010, 4'b0010, 1, 1, 0, '0, 1, 4'b0010, 1, 1, 4'b0010, 4'b0000, 1, 0));
        vq.push_back(mk(4'b0000, 4'b0100, 0, 0, 0, '0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0));
        vq.push_back(mk(4'b0000, 4'b0100, 0, 1, 0, '0, 0, 4'b0000, 0, 1, 4'b0100, 4'b0000, 2, 0));
        vq.push_back(mk(4'b0000, 4'b0000, 0, 0, 1, d3, 0, 4'b0000, 0, 0, 4'b0000, 4'b0010, 0, 0));
        vq.push_back(mk(4'b0000, 4'b0000, 0, 0, 1, d4, 0, 4'b0000, 0, 0, 4'b0000, 4'b0100, 0, 0));
        // stray return with nothing outstanding
        vq.push_back(mk(4'b0000, 4'b0000, 0, 0, 1, d1, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0));
        vq.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, '0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1));

        // reset state
        repeat (3) @(negedge clk);
        check("rst wr_0_req", sif.wr_0_req, 0);
        check("rst rd_0_req", sif.rd_0_req, 0);
        check("rst cl_wr_ack", sif.cl_wr_ack, 0);
        check("rst cl_rd_ack", sif.cl_rd_ack, 0);
        check("rst cl_rd_vld", sif.cl_rd_vld, 0);
        check("rst rd_tag_err", sif.rd_tag_err, 0);
        check("rst wr_0_addr", sif.wr_0_addr, 0);
        check("rst wr_grant_cnt", sif.wr_grant_cnt, 0);
        reset = 1'b1;

        foreach (vq[i]) begin
            @(posedge clk);
            #1;
            sif.cl_wr_req = vq[i].wr_req;
            sif.cl_rd_req = vq[i].rd_req;
            sif.wr_0_ack  = vq[i].wr_ack;
            sif.rd_0_ack  = vq[i].rd_ack;
            sif.rd_0_vld  = vq[i].rd_vld;
            sif.rd_0_data = vq[i].rd_data;
            @(negedge clk);
            check($sformatf("v%0d wr_0_req", i), sif.wr_0_req, vq[i].e_wr_req);
            check($sformatf("v%0d cl_wr_ack", i), sif.cl_wr_ack, vq[i].e_wr_ack);
            check($sformatf("v%0d rd_0_req", i), sif.rd_0_req, vq[i].e_rd_req);
            check($sformatf("v%0d cl_rd_ack", i), sif.cl_rd_ack, vq[i].e_rd_ack);
            check($sformatf("v%0d cl_rd_vld", i), sif.cl_rd_vld, vq[i].e_rd_vld);
            check($sformatf("v%0d cl_rd_data", i), sif.cl_rd_data, vq[i].rd_data);
            check($sformatf("v%0d rd_tag_err", i), sif.rd_tag_err, vq[i].e_err);
            if (vq[i].e_wr_req) begin
                check($sformatf("v%0d wr_0_addr", i), sif.wr_0_addr, A'(32'h10 + vq[i].e_wr_cl));
                check($sformatf("v%0d wr_0_data", i), sif.wr_0_data, D'(32'hAB + vq[i].e_wr_cl));
            end
            if (vq[i].e_rd_req)
                check($sformatf("v%0d rd_0_addr", i), sif.rd_0_addr, A'(32'h100 + vq[i].e_rd_cl));
        end
        @(posedge clk);
        #1;
        sif.cl_wr_req = '0; sif.cl_rd_req = '0;
        sif.wr_0_ack = 1'b0; sif.rd_0_ack = 1'b0; sif.rd_0_vld = 1'b0;

        // back-pressure: client 3 reads with returns held off
        sif.cl_rd_req = 4'b1000;
        acks = 0;
        repeat (30) begin
            @(negedge clk);
            sif.rd_0_ack = sif.rd_0_req;
            #1;
            if (sif.cl_rd_ack[3]) acks++;
        end
        @(negedge clk);
        sif.rd_0_ack = 1'b0;
        check("bp acks at limit", acks, 8);
        check("bp rd_0_req blocked", sif.rd_0_req, 0);
        sif.rd_0_vld = 1'b1;
        #1;
        check("bp one return", sif.cl_rd_vld, 4'b1000);
        @(negedge clk);
        sif.rd_0_vld = 1'b0;
        repeat (10) begin
            sif.rd_0_ack = sif.rd_0_req;
            #1;
            if (sif.cl_rd_ack[3]) acks++;
            @(negedge clk);
        end
        sif.rd_0_ack = 1'b0;
        check("bp acks after return", acks, 9);
        check("bp rd_0_req blocked again", sif.rd_0_req, 0);
        sif.cl_rd_req = '0;
        vlds = 0;
        repeat (8) begin
            sif.rd_0_vld = 1'b1;
            #1;
            if (sif.cl_rd_vld == 4'b1000) vlds++;
            @(negedge clk);
        end
        sif.rd_0_vld = 1'b0;
        check("bp drained returns", vlds, 8);

        // reset in the middle of a write grant with one read tag outstanding
        @(negedge clk);
        sif.cl_wr_req = 4'b0100;
        sif.cl_rd_req = 4'b0001;
        @(negedge clk);
        check("mid wr_0_req", sif.wr_0_req, 1);
        check("mid rd_0_req", sif.rd_0_req, 1);
        sif.rd_0_ack = 1'b1;
        #1;
        check("mid cl_rd_ack", sif.cl_rd_ack, 4'b0001);
        @(negedge clk);
        sif.rd_0_ack = 1'b0;
        sif.cl_rd_req = '0;
        reset = 1'b0;
        #1;
        check("mid rst wr_0_req", sif.wr_0_req, 0);
        check("mid rst rd_tag_err", sif.rd_tag_err, 0);
        @(negedge clk);
        reset = 1'b1;
        sif.cl_wr_req = '0;
        @(negedge clk);
        check("post rst wr_0_req", sif.wr_0_req, 0);
        sif.rd_0_vld = 1'b1;
        #1;
        check("post rst stale vld", sif.cl_rd_vld, 0);
        @(negedge clk);
        sif.rd_0_vld = 1'b0;
        check("post rst rd_tag_err", sif.rd_tag_err, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // grant statistics
        do_write(0); do_write(1); do_write(2); do_write(3); do_write(0);
        do_read(1); do_read(2); do_read(3);
`ifdef SRAM_ARB_STATS_EN
        exp_w = 5;
        exp_r = 3;
`else
        exp_w = 0;
        exp_r = 0;
`endif
        @(negedge clk);
        check("wr_grant_cnt", sif.wr_grant_cnt, exp_w);
        check("rd_grant_cnt", sif.rd_grant_cnt, exp_r);
        check("final rd_tag_err", sif.rd_tag_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
